// File: rtl/addsub_nibble_serial_if.sv
// addsub_nibble_serial_if: operand/result handshake bundle for the nibble-serial add/sub engine
interface addsub_nibble_serial_if #(parameter int W = 16);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry;
    logic         overflow;
    logic         busy;
    modport master (
        output in_valid, op_a, op_b, sub, out_ready,
        input  in_ready, out_valid, result, carry, overflow, busy
    );
    modport slave (
        input  in_valid, op_a, op_b, sub, out_ready,
        output in_ready, out_valid, result, carry, overflow, busy
    );
endinterface

// File: rtl/addsub_nibble_serial.sv
// addsub_nibble_serial: multi-word add/sub, one 4-bit CLA slice per cycle, LSB nibble first
module addsub_nibble_serial #(
    parameter int NIBBLES = 4
) (
    input logic                   clk,
    input logic                   reset,
    addsub_nibble_serial_if.slave bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES) + 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t         state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d, acc_q, acc_d, result_q, result_d;
    logic           sub_q, sub_d, cin_q, cin_d, carry_q, carry_d, ovf_q, ovf_d;
    logic [3:0]     na, nb, g, p, sum;
    logic [4:0]     c;
    assign na = a_q[3:0];
    assign nb = b_q[3:0] ^ {4{sub_q}};
    assign g  = na & nb;
    assign p  = na ^ nb;
    assign c[0] = cin_q;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);
    assign sum = p ^ c[3:0];
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        sub_d    = sub_q;
        cin_d    = cin_q;
        acc_d    = acc_q;
        result_d = result_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                a_d     = bus.op_a;
                b_d     = bus.op_b;
                sub_d   = bus.sub;
                cin_d   = bus.sub;
                idx_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                // operands shift down so the slice always sees the bottom nibble; sums enter at the top
                acc_d = (acc_q >> 4) | (W'(sum) << (W - 4));
                a_d   = a_q >> 4;
                b_d   = b_q >> 4;
                cin_d = c[4];
                idx_d = idx_q + IW'(1);
                if (idx_q == IW'(NIBBLES - 1)) begin
                    result_d = acc_d;
                    carry_d  = c[4];
                    ovf_d    = c[3] ^ c[4];
                    state_d  = DONE;
                end
            end
            DONE: state_d = bus.out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            cin_q    <= 1'b0;
            acc_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sub_q    <= sub_d;
            cin_q    <= cin_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
        end
    end
    assign bus.in_ready  = state_q == IDLE;
    assign bus.out_valid = state_q == DONE;
    assign bus.busy      = state_q != IDLE;
    assign bus.result    = result_q;
    assign bus.carry     = carry_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_addsub_nibble_serial.sv
// tb_addsub_nibble_serial: directed checks of the 16-bit engine and a NIBBLES=1 instance
module tb_addsub_nibble_serial;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;
    always #5 clk = ~clk;
    addsub_nibble_serial_if #(.W(16)) b4 ();
    addsub_nibble_serial_if #(.W(4))  b1 ();
    addsub_nibble_serial #(.NIBBLES(4)) dut4 (.clk(clk), .reset(reset), .bus(b4));
    addsub_nibble_serial #(.NIBBLES(1)) dut1 (.clk(clk), .reset(reset), .bus(b1));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done4(output int n);
        n = 0;
        while (!b4.out_valid && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic op4(input logic [15:0] a, input logic [15:0] b, input logic s, output int lat);
        b4.op_a = a; b4.op_b = b; b4.sub = s; b4.in_valid = 1'b1;
        tick();
        b4.in_valid = 1'b0; b4.op_a = ~a; b4.op_b = ~b; b4.sub = ~s;
        wait_done4(lat);
    endtask

    task automatic release4();
        b4.out_ready = 1'b1;
        tick();
        b4.out_ready = 1'b0;
    endtask

    task automatic op1(input logic [3:0] a, input logic [3:0] b, input logic s, output int lat);
        b1.op_a = a; b1.op_b = b; b1.sub = s; b1.in_valid = 1'b1;
        tick();
        b1.in_valid = 1'b0;
        lat = 0;
        while (!b1.out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        tick(); tick();
        tests++; if (b4.in_ready !== 1'b1 || b4.out_valid !== 1'b0 || b4.busy !== 1'b0) begin fails++; $display("FAIL reset_ctrl got rdy=%b vld=%b busy=%b want 1 0 0", b4.in_ready, b4.out_valid, b4.busy); end
        tests++; if ({b4.result, b4.carry, b4.overflow} !== 18'h0) begin fails++; $display("FAIL reset_out got %h want 0", {b4.result, b4.carry, b4.overflow}); end
        tests++; if (b1.in_ready !== 1'b1 || b1.out_valid !== 1'b0 || b1.result !== 4'h0) begin fails++; $display("FAIL reset_n1 got rdy=%b vld=%b res=%h want 1 0 0", b1.in_ready, b1.out_valid, b1.result); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_add();
        int lat;
        op4(16'h1234, 16'h0FCD, 1'b0, lat);
        tests++; if (lat !== 4) begin fails++; $display("FAIL add_latency got %0d want 4", lat); end
        tests++; if ({b4.result, b4.carry, b4.overflow} !== {16'h2201, 1'b0, 1'b0}) begin fails++; $display("FAIL add got %h c=%b v=%b want 2201 0 0", b4.result, b4.carry, b4.overflow); end
        tests++; if (b4.in_ready !== 1'b0 || b4.busy !== 1'b1) begin fails++; $display("FAIL done_ctrl got rdy=%b busy=%b want 0 1", b4.in_ready, b4.busy); end
        release4();
        tests++; if (b4.out_valid !== 1'b0 || b4.in_ready !== 1'b1) begin fails++; $display("FAIL add_release got vld=%b rdy=%b want 0 1", b4.out_valid, b4.in_ready); end
    endtask

    task automatic test_overflow();
        int lat;
        op4(16'h7FFF, 16'h0001, 1'b0, lat);
        tests++; if ({b4.result, b4.carry, b4.overflow} !== {16'h8000, 1'b0, 1'b1}) begin fails++; $display("FAIL ovf_pos got %h c=%b v=%b want 8000 0 1", b4.result, b4.carry, b4.overflow); end
        release4();
        op4(16'hFFFF, 16'h0001, 1'b0, lat);
        tests++; if ({b4.result, b4.carry, b4.overflow} !== {16'h0000, 1'b1, 1'b0}) begin fails++; $display("FAIL carry_wrap got %h c=%b v=%b want 0000 1 0", b4.result, b4.carry, b4.overflow); end
        release4();
    endtask

    task automatic test_sub();
        int lat;
        op4(16'h0000, 16'h0001, 1'b1, lat);
        tests++; if ({b4.result, b4.carry, b4.overflow} !== {16'hFFFF, 1'b0, 1'b0}) begin fails++; $display("FAIL sub_borrow got %h c=%b v=%b want ffff 0 0", b4.result, b4.carry, b4.overflow); end
        release4();
        op4(16'h8000, 16'h0001, 1'b1, lat);
        tests++; if ({b4.result, b4.carry, b4.overflow} !== {16'h7FFF, 1'b1, 1'b1}) begin fails++; $display("FAIL sub_ovf got %h c=%b v=%b want 7fff 1 1", b4.result, b4.carry, b4.overflow); end
        release4();
    endtask

    task automatic test_backpressure();
        int lat;
        int bad = 0;
        op4(16'h1234, 16'h0FCD, 1'b0, lat);
        b4.op_a = 16'h0001; b4.op_b = 16'h0002; b4.sub = 1'b0; b4.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (b4.out_valid !== 1'b1 || b4.in_ready !== 1'b0 || b4.result !== 16'h2201 || b4.carry !== 1'b0 || b4.overflow !== 1'b0) bad++;
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL bp_hold got %0d bad cycles want 0", bad); end
        b4.out_ready = 1'b1;
        tick();
        b4.out_ready = 1'b0;
        tests++; if (b4.in_ready !== 1'b1 || b4.out_valid !== 1'b0) begin fails++; $display("FAIL bp_idle got rdy=%b vld=%b want 1 0", b4.in_ready, b4.out_valid); end
        tick();
        b4.in_valid = 1'b0;
        tests++; if (b4.busy !== 1'b1) begin fails++; $display("FAIL bp_accept got busy=%b want 1", b4.busy); end
        wait_done4(lat);
        tests++; if (lat !== 4 || b4.result !== 16'h0003) begin fails++; $display("FAIL bp_next got lat=%0d res=%h want 4 0003", lat, b4.result); end
        release4();
    endtask

    task automatic test_reset_mid_run();
        int lat;
        b4.op_a = 16'h1234; b4.op_b = 16'h0FCD; b4.sub = 1'b0; b4.in_valid = 1'b1;
        tick();
        b4.in_valid = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++; if (b4.in_ready !== 1'b1 || b4.out_valid !== 1'b0 || b4.busy !== 1'b0 || b4.result !== 16'h0) begin fails++; $display("FAIL mid_reset got rdy=%b vld=%b busy=%b res=%h want 1 0 0 0000", b4.in_ready, b4.out_valid, b4.busy, b4.result); end
        op4(16'h0001, 16'h0001, 1'b0, lat);
        tests++; if (lat !== 4 || {b4.result, b4.carry, b4.overflow} !== {16'h0002, 1'b0, 1'b0}) begin fails++; $display("FAIL post_reset got lat=%0d res=%h c=%b v=%b want 4 0002 0 0", lat, b4.result, b4.carry, b4.overflow); end
        release4();
    endtask

    task automatic test_single_nibble();
        int lat;
        op1(4'h7, 4'h1, 1'b0, lat);
        tests++; if (lat !== 1 || {b1.result, b1.carry, b1.overflow} !== {4'h8, 1'b0, 1'b1}) begin fails++; $display("FAIL n1_add got lat=%0d res=%h c=%b v=%b want 1 8 0 1", lat, b1.result, b1.carry, b1.overflow); end
        b1.out_ready = 1'b1; tick(); b1.out_ready = 1'b0;
        op1(4'h3, 4'h5, 1'b1, lat);
        tests++; if (lat !== 1 || {b1.result, b1.carry, b1.overflow} !== {4'hE, 1'b0, 1'b0}) begin fails++; $display("FAIL n1_sub got lat=%0d res=%h c=%b v=%b want 1 e 0 0", lat, b1.result, b1.carry, b1.overflow); end
        b1.out_ready = 1'b1; tick(); b1.out_ready = 1'b0;
    endtask

    initial begin
        b4.in_valid = 1'b0; b4.op_a = '0; b4.op_b = '0; b4.sub = 1'b0; b4.out_ready = 1'b0;
        b1.in_valid = 1'b0; b1.op_a = '0; b1.op_b = '0; b1.sub = 1'b0; b1.out_ready = 1'b0;
        test_reset();
        test_add();
        test_overflow();
        test_sub();
        test_backpressure();
        test_reset_mid_run();
        test_single_nibble();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
